// File: rtl/tspi_shift_engine.sv
// tspi_shift_engine: command-driven TSPI transaction sequencer.
// Shifts a variable-length command out on MOSI, waits for the device start
// bit (MISO low), shifts in a variable-length response, and returns it
// over a valid/ready handshake. Serial actions are enabled by rising
// edges of tspi_clk_i, detected in the clk_i domain.
// Optional feature macro: TSPI_SHIFT_TIMEOUT_EN (start-bit timeout).
module tspi_shift_engine #(
   parameter int DataWidth    = 32,
   parameter int LenWidth     = $clog2(DataWidth) + 1,
   parameter int TimeoutEdges = 1024
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 tspi_clk_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [LenWidth-1:0]  cmd_tx_len_i,
   input  logic [LenWidth-1:0]  cmd_rx_len_i,
   input  logic [DataWidth-1:0] cmd_data_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [DataWidth-1:0] rsp_data_o,
   output logic                 rsp_timeout_o,
   output logic                 mosi_o,
   input  logic                 miso_i,
   output logic                 busy_o
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_TX   = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_RX   = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [LenWidth-1:0] MaxLen = LenWidth'(DataWidth);

   // Elaboration-time parameter sanity check.
   if (DataWidth < 2 || TimeoutEdges < 1) begin : g_bad_param
      $error("tspi_shift_engine: DataWidth must be >= 2 and TimeoutEdges >= 1");
   end

   logic [2:0]           r_state;
   logic                 r_tspi_q;
   logic [LenWidth-1:0]  r_tx_len;
   logic [LenWidth-1:0]  r_rx_len;
   logic [LenWidth-1:0]  r_cnt;
   logic [DataWidth-1:0] r_tx_sh;
   logic [DataWidth-1:0] r_rx_q;

   logic                 w_edge;
   logic [LenWidth-1:0]  w_tx_len_c;
   logic [LenWidth-1:0]  w_rx_len_c;
   logic [LenWidth-1:0]  w_tx_sh_amt;
   logic [LenWidth-1:0]  w_cnt_nxt;

   assign w_edge      = tspi_clk_i & ~r_tspi_q;
   // Lengths above DataWidth are clamped so the shifter never over-runs.
   assign w_tx_len_c  = (cmd_tx_len_i > MaxLen) ? MaxLen : cmd_tx_len_i;
   assign w_rx_len_c  = (cmd_rx_len_i > MaxLen) ? MaxLen : cmd_rx_len_i;
   // MSB-align the payload; a zero length shifts everything out (result 0).
   assign w_tx_sh_amt = MaxLen - w_tx_len_c;
   assign w_cnt_nxt   = r_cnt + LenWidth'(1);

`ifdef TSPI_SHIFT_TIMEOUT_EN
   localparam int TmoW = $clog2(TimeoutEdges + 1);

   logic [TmoW-1:0] r_tmo_cnt;
   logic [TmoW-1:0] w_tmo_nxt;
   logic            w_tmo_hit;
   logic            r_timeout;

   assign w_tmo_nxt = r_tmo_cnt + TmoW'(1);
   assign w_tmo_hit = w_edge && (w_tmo_nxt == TmoW'(TimeoutEdges));

   // Count TSPI edges spent in WAIT_START; held at zero in every other state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_tmo_cnt <= '0;
      end else if (r_state != S_WAIT) begin
         r_tmo_cnt <= '0;
      end else if (w_edge) begin
         r_tmo_cnt <= w_tmo_nxt;
      end
   end

   assign rsp_timeout_o = r_timeout;
`else
   assign rsp_timeout_o = 1'b0;
`endif

   // Register the TSPI clock for rising-edge detection.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_tspi_q <= 1'b0;
      end else begin
         r_tspi_q <= tspi_clk_i;
      end
   end

   // Transaction sequencer: command accept, TX shift, start-bit wait, RX shift, response hold.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         r_tx_len <= '0;
         r_rx_len <= '0;
         r_cnt    <= '0;
         r_tx_sh  <= '0;
         r_rx_q   <= '0;
`ifdef TSPI_SHIFT_TIMEOUT_EN
         r_timeout <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               // An edge coinciding with acceptance is deliberately not counted.
               if (cmd_valid_i) begin
                  r_tx_len <= w_tx_len_c;
                  r_rx_len <= w_rx_len_c;
                  r_tx_sh  <= cmd_data_i << w_tx_sh_amt;
                  r_rx_q   <= '0;
                  r_cnt    <= '0;
`ifdef TSPI_SHIFT_TIMEOUT_EN
                  r_timeout <= 1'b0;
`endif
                  if (w_tx_len_c != '0) begin
                     r_state <= S_TX;
                  end else if (w_rx_len_c != '0) begin
                     r_state <= S_WAIT;
                  end else begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_TX: begin
               if (w_edge) begin
                  r_tx_sh <= {r_tx_sh[DataWidth-2:0], 1'b0};
                  if (w_cnt_nxt == r_tx_len) begin
                     r_cnt   <= '0;
                     r_state <= (r_rx_len != '0) ? S_WAIT : S_DONE;
                  end else begin
                     r_cnt <= w_cnt_nxt;
                  end
               end
            end
            S_WAIT: begin
               // The start bit itself is consumed, not stored.
               if (w_edge && !miso_i) begin
                  r_state <= S_RX;
`ifdef TSPI_SHIFT_TIMEOUT_EN
               end else if (w_tmo_hit) begin
                  r_state   <= S_DONE;
                  r_timeout <= 1'b1;
`endif
               end
            end
            S_RX: begin
               if (w_edge) begin
                  r_rx_q <= {r_rx_q[DataWidth-2:0], miso_i};
                  if (w_cnt_nxt == r_rx_len) begin
                     r_cnt   <= '0;
                     r_state <= S_DONE;
                  end else begin
                     r_cnt <= w_cnt_nxt;
                  end
               end
            end
            S_DONE: begin
               if (rsp_ready_i) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready_o = (r_state == S_IDLE);
   assign rsp_valid_o = (r_state == S_DONE);
   assign busy_o      = (r_state != S_IDLE);
   assign rsp_data_o  = r_rx_q;
   assign mosi_o      = (r_state == S_TX) ? r_tx_sh[DataWidth-1] : 1'b1;

endmodule

// File: tb/tb_tspi_shift_engine.sv
// tb_tspi_shift_engine: directed self-checking bench for tspi_shift_engine.
// Expected MOSI bits and responses are queued when a command is issued and
// popped as the DUT produces them. Honours TSPI_SHIFT_TIMEOUT_EN.
module tb_tspi_shift_engine;

   localparam int DW  = 32;
   localparam int LW  = $clog2(DW) + 1;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          tspi;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [LW-1:0] tx_len;
   logic [LW-1:0] rx_len;
   logic [DW-1:0] cmd_data;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          rsp_timeout;
   logic          mosi;
   logic          miso;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   logic [DW:0] rsp_q[$];   // {timeout, data}
   logic        mosi_q[$];

   tspi_shift_engine #(
      .DataWidth(DW),
      .LenWidth(LW),
      .TimeoutEdges(TMO)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .tspi_clk_i(tspi),
      .cmd_valid_i(cmd_valid),
      .cmd_ready_o(cmd_ready),
      .cmd_tx_len_i(tx_len),
      .cmd_rx_len_i(rx_len),
      .cmd_data_i(cmd_data),
      .rsp_valid_o(rsp_valid),
      .rsp_ready_i(rsp_ready),
      .rsp_data_o(rsp_data),
      .rsp_timeout_o(rsp_timeout),
      .mosi_o(mosi),
      .miso_i(miso),
      .busy_o(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One TSPI bit period: high for one clk cycle, low for one. Starts and ends at a negedge.
   task automatic tbit(input logic m, output logic mo);
      mo   = mosi;
      miso = m;
      tspi = 1'b1;
      cyc();
      tspi = 1'b0;
      cyc();
   endtask

   function automatic int clampl(input int l);
      return (l > DW) ? DW : l;
   endfunction

   task automatic expect_cmd(input int txl, input int rxl, input logic [DW-1:0] d,
                             input logic [DW-1:0] rxval, input logic tmo);
      int cx;
      int cr;
      logic [63:0] mask;
      cx = clampl(txl);
      cr = clampl(rxl);
      for (int i = cx - 1; i >= 0; i--) mosi_q.push_back(d[i]);
      mask = (64'd1 << cr) - 64'd1;
      if (tmo) rsp_q.push_back({1'b1, {DW{1'b0}}});
      else     rsp_q.push_back({1'b0, rxval & mask[DW-1:0]});
   endtask

   task automatic send_cmd(input int txl, input int rxl, input logic [DW-1:0] d);
      chk("cmd_ready_before_cmd", cmd_ready, 1);
      cmd_valid = 1'b1;
      tx_len    = LW'(txl);
      rx_len    = LW'(rxl);
      cmd_data  = d;
      cyc();
      cmd_valid = 1'b0;
      chk("busy_after_accept", busy, 1);
      chk("cmd_ready_after_accept", cmd_ready, 0);
   endtask

   task automatic get_rsp(input int budget, input int stall);
      int n;
      logic [DW:0] e;
      n = 0;
      while (!rsp_valid && n < budget) begin
         cyc();
         n++;
      end
      chk("rsp_valid_rise", rsp_valid, 1);
      chk("sb_nonempty", rsp_q.size() != 0, 1);
      e = (rsp_q.size() != 0) ? rsp_q.pop_front() : '0;
      chk("rsp_data", rsp_data, e[DW-1:0]);
      chk("rsp_timeout", rsp_timeout, e[DW]);
      for (int i = 0; i < stall; i++) begin
         if (i == 3) begin
            cmd_valid = 1'b1;
            cmd_data  = 32'hFFFF_FFFF;
            tx_len    = LW'(4);
            rx_len    = LW'(4);
         end
         cyc();
         cmd_valid = 1'b0;
         chk("stall_valid", rsp_valid, 1);
         chk("stall_data", rsp_data, e[DW-1:0]);
         chk("stall_cmd_ready", cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      chk("post_rsp_valid", rsp_valid, 0);
      chk("post_rsp_cmd_ready", cmd_ready, 1);
      chk("post_rsp_busy", busy, 0);
      chk("post_rsp_mosi", mosi, 1);
   endtask

   task automatic run_txn(input int txl, input int rxl, input logic [DW-1:0] d,
                          input logic [DW-1:0] rxval, input int hold, input int stall);
      int cx;
      int cr;
      logic mo;
      logic e;
      cx = clampl(txl);
      cr = clampl(rxl);
      expect_cmd(txl, rxl, d, rxval, 1'b0);
      send_cmd(txl, rxl, d);
      for (int i = 0; i < cx; i++) begin
         tbit(1'b1, mo);
         e = (mosi_q.size() != 0) ? mosi_q.pop_front() : 1'bx;
         chk("mosi_bit", mo, e);
      end
      if (cr > 0) begin
         for (int h = 0; h < hold; h++) begin
            tbit(1'b1, mo);
            chk("mosi_idle_hold", mo, 1);
            chk("busy_hold", busy, 1);
         end
         tbit(1'b0, mo);
         chk("mosi_idle_start", mo, 1);
         for (int i = 0; i < cr; i++) begin
            tbit(rxval[cr-1-i], mo);
            chk("mosi_idle_rx", mo, 1);
         end
      end
      get_rsp(2, stall);
   endtask

   initial begin
      logic mo;
      rst       = 1'b1;
      tspi      = 1'b0;
      miso      = 1'b1;
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      tx_len    = '0;
      rx_len    = '0;
      cmd_data  = '0;
      repeat (3) cyc();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_timeout", rsp_timeout, 0);
      chk("rst_mosi", mosi, 1);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      cyc();

      // Basic, full width, start-bit hold-off
      run_txn(8, 8, 32'h0000_00A5, 32'h0000_003C, 0, 0);
      run_txn(32, 32, 32'hDEAD_BEEF, 32'h1234_5678, 0, 0);
      run_txn(8, 8, 32'h0000_0081, 32'h0000_00C3, 5, 0);

      // Zero-length and clamp cases
      run_txn(0, 4, 32'h0000_FFFF, 32'h0000_000A, 0, 0);
      run_txn(40, 8, 32'hCAFE_F00D, 32'h0000_0005, 0, 0);
      run_txn(8, 0, 32'h0000_003C, 32'h0000_0000, 0, 0);
      run_txn(0, 0, 32'h0000_1234, 32'h0000_0000, 0, 0);

      // Response stall with an ignored command during DONE
      run_txn(6, 5, 32'h0000_002D, 32'h0000_0013, 1, 10);

      // Reset pulsed during RX
      send_cmd(8, 8, 32'h0000_005A);
      for (int i = 0; i < 8; i++) tbit(1'b1, mo);
      tbit(1'b0, mo);
      for (int i = 0; i < 3; i++) tbit(1'b1, mo);
      chk("pre_rst_data", rsp_data, 32'h7);
      rst = 1'b1;
      #1;
      chk("midrst_cmd_ready", cmd_ready, 1);
      chk("midrst_rsp_valid", rsp_valid, 0);
      chk("midrst_rsp_data", rsp_data, 0);
      chk("midrst_rsp_timeout", rsp_timeout, 0);
      chk("midrst_mosi", mosi, 1);
      chk("midrst_busy", busy, 0);
      cyc();
      rst = 1'b0;
      cyc();
      run_txn(16, 12, 32'h0000_BEEF, 32'h0000_0ABC, 2, 0);

      // MISO stuck high in WAIT_START
`ifdef TSPI_SHIFT_TIMEOUT_EN
      expect_cmd(4, 4, 32'h0000_0009, 32'h0, 1'b1);
      send_cmd(4, 4, 32'h0000_0009);
      for (int i = 0; i < 4; i++) begin
         tbit(1'b1, mo);
         chk("tmo_mosi_bit", mo, mosi_q.size() != 0 ? mosi_q.pop_front() : 1'bx);
      end
      for (int i = 0; i < TMO - 1; i++) tbit(1'b1, mo);
      chk("tmo_not_yet_valid", rsp_valid, 0);
      chk("tmo_busy", busy, 1);
      tbit(1'b1, mo);
      get_rsp(2, 0);
`else
      expect_cmd(4, 4, 32'h0000_0009, 32'h0000_0006, 1'b0);
      send_cmd(4, 4, 32'h0000_0009);
      for (int i = 0; i < 4; i++) begin
         tbit(1'b1, mo);
         chk("wait_mosi_bit", mo, mosi_q.size() != 0 ? mosi_q.pop_front() : 1'bx);
      end
      for (int i = 0; i < 40; i++) begin
         tbit(1'b1, mo);
         if (i % 10 == 9) begin
            chk("wait_busy", busy, 1);
            chk("wait_no_rsp", rsp_valid, 0);
         end
      end
      tbit(1'b0, mo);
      for (int i = 0; i < 4; i++) tbit(4'h6 >> (3 - i), mo);
      get_rsp(2, 0);
`endif

      chk("sb_drained_rsp", rsp_q.size(), 0);
      chk("sb_drained_mosi", mosi_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
